// File: rtl/inst_trace_buffer.sv
// Trace capture FIFO for committed pc/inst pairs, drained through a valid/ready port.
// Build option: INST_TRACE_HALT_DETECT_EN enables self-loop halt detection that freezes capture.

`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module inst_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = `ADDR_LEN,
    parameter int INST_W = `INSTR_LEN,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_en,
    input  logic [ADDR_W-1:0] pc,
    input  logic [INST_W-1:0] inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [CNT_W-1:0]  occupancy,
    output logic [31:0]       retired_cnt,
    output logic              overflow,
    output logic              halted
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = ADDR_W + INST_W;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] head;
    logic [PTR_W-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic [31:0]      retired_q, retired_d;
    logic             overflow_q, overflow_d;
    logic             full, empty, cap, pop, push, drop;

    assign full  = (occ_q == CNT_W'(DEPTH));
    assign empty = (occ_q == '0);
    assign cap   = cap_en & ~halted;
    assign pop   = out_valid & out_ready;
    assign push  = cap & (~full | pop);
    assign drop  = cap & full & ~pop;

    always_comb begin
        wp_d       = wp_q;
        rp_d       = rp_q;
        occ_d      = occ_q;
        retired_d  = retired_q;
        overflow_d = overflow_q;
        if (push) wp_d = wp_q + PTR_W'(1);
        if (pop)  rp_d = rp_q + PTR_W'(1);
        occ_d = occ_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
        if (cap)  retired_d = retired_q + 32'd1;
        if (drop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q       <= '0;
            rp_q       <= '0;
            occ_q      <= '0;
            retired_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            occ_q      <= occ_d;
            retired_q  <= retired_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wp_q] <= {pc, inst};
    end

`ifdef INST_TRACE_HALT_DETECT_EN
    logic [ADDR_W-1:0] last_pc_q, last_pc_d;
    logic              last_vld_q, last_vld_d;
    logic              halted_q, halted_d;

    always_comb begin
        last_pc_d  = last_pc_q;
        last_vld_d = last_vld_q;
        halted_d   = halted_q;
        if (cap) begin
            last_pc_d  = pc;
            last_vld_d = 1'b1;
            if (last_vld_q && (pc == last_pc_q)) halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_pc_q  <= '0;
            last_vld_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            last_pc_q  <= last_pc_d;
            last_vld_q <= last_vld_d;
            halted_q   <= halted_d;
        end
    end

    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

    assign head        = mem_q[rp_q];
    assign out_valid   = ~empty;
    assign out_pc      = empty ? '0 : head[ENT_W-1:INST_W];
    assign out_inst    = empty ? '0 : head[INST_W-1:0];
    assign occupancy   = occ_q;
    assign retired_cnt = retired_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_inst_trace_buffer.sv
// Scoreboard bench for inst_trace_buffer: driver queues expected entries, monitor checks pops.
// Halt expectations follow INST_TRACE_HALT_DETECT_EN.

module tb_inst_trace_buffer;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cap_en = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] inst = '0;
    logic        out_valid;
    logic [31:0] out_pc, out_inst;
    logic [4:0]  occupancy;
    logic [31:0] retired_cnt;
    logic        overflow, halted;

    int n_checks = 0;
    int n_pass = 0;
    logic [63:0] exp_q [$];
    int          mdl_occ = 0;
    logic        mdl_halted = 1'b0;
    logic        mdl_last_vld = 1'b0;
    logic [31:0] mdl_last_pc = '0;

    inst_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cap_en(cap_en), .pc(pc), .inst(inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .occupancy(occupancy), .retired_cnt(retired_cnt), .overflow(overflow), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic cycle(input logic c, input logic [31:0] p, input logic [31:0] i, input logic r);
        logic pop_m, cap_m, push_m;
        @(negedge clk); #1;
        rst = 1'b0; cap_en = c; pc = p; inst = i; out_ready = r;
        pop_m  = (mdl_occ > 0) && r;
        cap_m  = c && !mdl_halted;
        push_m = cap_m && ((mdl_occ < DEPTH) || pop_m);
        if (push_m) exp_q.push_back({p, i});
        mdl_occ = mdl_occ + int'(push_m) - int'(pop_m);
`ifdef INST_TRACE_HALT_DETECT_EN
        if (cap_m) begin
            if (mdl_last_vld && (p == mdl_last_pc)) mdl_halted = 1'b1;
            mdl_last_pc  = p;
            mdl_last_vld = 1'b1;
        end
`endif
        @(posedge clk); #2;
    endtask

    task automatic do_reset(input logic c, input logic r);
        @(negedge clk); #1;
        rst = 1'b1; cap_en = c; out_ready = r; pc = 32'h0000_0BAD; inst = 32'hDEAD_BEEF;
        @(posedge clk);
        exp_q.delete();
        mdl_occ = 0; mdl_halted = 1'b0; mdl_last_vld = 1'b0; mdl_last_pc = '0;
        #2;
    endtask

    initial begin : monitor
        logic [63:0] e;
        forever begin
            @(negedge clk); #3;
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL pop_unexpected: got pop of out_pc %0h, expected no entry", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_pc", {32'h0, out_pc}, {32'h0, e[63:32]});
                    check("pop_inst", {32'h0, out_inst}, {32'h0, e[31:0]});
                end
            end
        end
    end

    initial begin
        // Reset state
        do_reset(1'b0, 1'b0);
        check("rst_valid", out_valid, 0);
        check("rst_pc", out_pc, 0);
        check("rst_occ", occupancy, 0);
        check("rst_retired", retired_cnt, 0);
        check("rst_overflow", overflow, 0);
        check("rst_halted", halted, 0);

        // Three captures held, then drained in order
        for (int k = 0; k < 3; k++) cycle(1'b1, 32'(4 * k), 32'h0000_0013, 1'b0);
        check("t1_occ", occupancy, 3);
        check("t1_retired", retired_cnt, 3);
        check("t1_head_pc", out_pc, 0);
        check("t1_valid", out_valid, 1);
        for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0, 32'h0, 1'b1);
        check("t1_empty_valid", out_valid, 0);
        check("t1_empty_pc", out_pc, 0);
        check("t1_empty_inst", out_inst, 0);
        check("t1_empty_occ", occupancy, 0);

        // Push with ready while empty: no pop, occupancy becomes 1
        cycle(1'b1, 32'h40, 32'h0000_0013, 1'b1);
        check("t1b_occ", occupancy, 1);
        check("t1b_pc", out_pc, 32'h40);
        cycle(1'b0, 32'h0, 32'h0, 1'b1);
        check("t1b_drain", occupancy, 0);

        // Overflow: 18 captures into 16 entries
        do_reset(1'b0, 1'b0);
        for (int k = 0; k < 18; k++) cycle(1'b1, 32'h100 + 32'(4 * k), 32'hA000_0000 + 32'(k), 1'b0);
        check("t2_occ", occupancy, 16);
        check("t2_overflow", overflow, 1);
        check("t2_retired", retired_cnt, 18);
        check("t2_head_pc", out_pc, 32'h100);

        // Full with simultaneous push/pop across the pointer wrap
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 32'h200 + 32'(4 * k), 32'hB000_0000 + 32'(k), 1'b1);
            if (k == 9) check("t3_occ_mid", occupancy, 16);
        end
        check("t3_occ", occupancy, 16);
        check("t3_overflow", overflow, 1);
        check("t3_head_pc", out_pc, 32'h210);
        check("t3_retired", retired_cnt, 38);
        for (int k = 0; k < 16; k++) cycle(1'b0, 32'h0, 32'h0, 1'b1);
        check("t3_drained", occupancy, 0);

        // Mid-stream reset with traffic on the inputs
        for (int k = 0; k < 5; k++) cycle(1'b1, 32'h280 + 32'(4 * k), 32'hC000_0000, 1'b0);
        check("t4_occ_pre", occupancy, 5);
        do_reset(1'b1, 1'b1);
        check("t4_valid", out_valid, 0);
        check("t4_occ", occupancy, 0);
        check("t4_retired", retired_cnt, 0);
        check("t4_overflow", overflow, 0);
        cycle(1'b1, 32'h300, 32'h0000_0093, 1'b0);
        check("t4_post_occ", occupancy, 1);
        check("t4_post_pc", out_pc, 32'h300);
        check("t4_post_inst", out_inst, 32'h0000_0093);
        check("t4_post_retired", retired_cnt, 1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1);

        // Self-loop halt
        do_reset(1'b0, 1'b0);
        cycle(1'b1, 32'h10, 32'h0000_0013, 1'b0);
        cycle(1'b1, 32'h14, 32'h0000_006F, 1'b0);
        cycle(1'b1, 32'h14, 32'h0000_006F, 1'b0);
`ifdef INST_TRACE_HALT_DETECT_EN
        check("t5_halt_3rd", halted, 1);
`else
        check("t5_halt_3rd", halted, 0);
`endif
        cycle(1'b1, 32'h14, 32'h0000_006F, 1'b0);
`ifdef INST_TRACE_HALT_DETECT_EN
        check("t5_halted", halted, 1);
        check("t5_retired", retired_cnt, 3);
        check("t5_occ", occupancy, 3);
`else
        check("t5_halted", halted, 0);
        check("t5_retired", retired_cnt, 4);
        check("t5_occ", occupancy, 4);
`endif
        for (int k = 0; k < 4; k++) cycle(1'b0, 32'h0, 32'h0, 1'b1);
        check("t5_drained", occupancy, 0);

        // Retired counter wrap
        do_reset(1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0);
        dut.retired_q = 32'hFFFF_FFFF;
        #1;
        check("t6_preset", retired_cnt, 32'hFFFF_FFFF);
        cycle(1'b1, 32'h500, 32'h0000_0013, 1'b1);
        check("t6_wrap", retired_cnt, 32'h0000_0000);
        cycle(1'b0, 32'h0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1);

        check("sb_empty", 64'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
